// File: rtl/lsu_pkg.sv
// Shared types for the MEM-stage load/store unit.
// States, access sizes and RV32I load/store funct3 encodings.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_X
  } lsu_size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic lsu_size_t f3_size(
    input logic [2:0] f3
  );
    lsu_size_t s;
    unique case (f3)
      F3_B, F3_BU: s = SZ_B;
      F3_H, F3_HU: s = SZ_H;
      F3_W:        s = SZ_W;
      default:     s = SZ_X;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: enables, replicated store data and
// sign/zero-extended load data for one funct3/offset pair.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  lsu_size_t   size;
  logic        sext;
  logic [31:0] sh;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    size      = f3_size(funct3);
    sext      = ~funct3[2];
    sh        = rdata >> {addr_lo, 3'b000};
    b         = sh[7:0];
    h         = addr_lo[1] ? rdata[31:16]
                           : rdata[15:0];
    be        = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    unique case (1'b1)
      size == SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sext & b[7]}}, b};
      end
      size == SZ_H: begin
        be        = addr_lo[1] ? 4'b1100
                               : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sext & h[15]}}, h};
      end
      size == SZ_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit with variable-latency memory handshake.
// Define MISALIGN_TRAP_EN to trap misaligned H/W instead of aligning.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_dest,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_dest,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT =
    CW'(TIMEOUT_CYC - 1);

  lsu_state_t  state, state_d;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [4:0]  dest_q;
  logic        we_q;
  logic [CW-1:0] cnt;

  lsu_size_t   rsz;
  logic        illegal, misal, bad;
  logic        accept, tmo;
  logic [2:0]  al_f3;
  logic [1:0]  al_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready;
  assign tmo       = (cnt == LIMIT);

  assign rsz     = f3_size(req_funct3);
  assign illegal = (rsz == SZ_X)
                 | (req_funct3[2] & req_we);
`ifdef MISALIGN_TRAP_EN
  assign misal = ((rsz == SZ_H) & req_addr[0])
               | ((rsz == SZ_W) & (req_addr[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif
  assign bad = illegal | misal;

  // Idle steers the incoming request; afterwards the latched one.
  assign al_f3 = req_ready ? req_funct3 : f3_q;
  assign al_lo = req_ready ? req_addr[1:0] : lo_q;

  lsu_align u_align (
    .funct3    (al_f3),
    .addr_lo   (al_lo),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (accept)
          state_d = bad ? RESP : ACCESS;
      ACCESS:
        if (mem_ack || tmo)
          state_d = RESP;
      RESP:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      f3_q      <= '0;
      lo_q      <= '0;
      dest_q    <= '0;
      we_q      <= 1'b0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_dest  <= '0;
      rsp_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_dest  <= '0;
      rsp_err   <= 1'b0;
      unique case (state)
        IDLE:
          if (accept) begin
            f3_q   <= req_funct3;
            lo_q   <= req_addr[1:0];
            dest_q <= req_dest;
            we_q   <= req_we;
            cnt    <= '0;
            if (bad) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_wen   <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= al_be;
              mem_wdata <= al_wdata;
            end
          end
        ACCESS:
          if (mem_ack || tmo) begin
            mem_req   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b1;
            // An ack on the limit cycle still completes normally.
            if (!mem_ack) begin
              rsp_err <= 1'b1;
            end else if (!we_q) begin
              rsp_data <= al_rdata;
              rsp_dest <= dest_q;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a response scoreboard.
// Follows MISALIGN_TRAP_EN for the misaligned word case.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_dest;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_dest;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dest;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  mem_stage_lsu #(
    .TIMEOUT_CYC (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_dest   (req_dest),
    .busy       (busy),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_dest   (rsp_dest),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) begin
        check("rsp_unexpected", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_dest", 32'(rsp_dest), 32'(e.dest));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  // delay < 0: memory never acks.
  task automatic access(
    input string       tag,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [4:0]  dest,
    input int          delay,
    input logic [31:0] rdata,
    input logic        issue,
    input logic [3:0]  be,
    input logic [31:0] mwd,
    input int          lat,
    input logic [31:0] edata,
    input logic [4:0]  edest,
    input logic        eerr
  );
    int          seen;
    logic        busy_ok;
    logic [31:0] maddr;
    maddr = {addr[31:2], 2'b00};
    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_dest   = dest;
    q.push_back('{edata, edest, eerr});
    @(posedge clk);
    #1;
    req_addr = ~addr;
    seen     = -1;
    busy_ok  = 1'b1;
    for (int k = 0; k < 40 && seen < 0; k++) begin
      @(negedge clk);
      busy_ok = busy_ok & busy;
      if (k == 0 && issue) begin
        check({tag, "_mreq"}, 32'(mem_req), 32'd1);
        check({tag, "_wen"}, 32'(mem_wen), 32'(we));
        check({tag, "_maddr"}, mem_addr, maddr);
        check({tag, "_be"}, 32'(mem_be), 32'(be));
        if (we)
          check({tag, "_mwdata"}, mem_wdata, mwd);
      end
      if (k == 0 && !issue)
        check({tag, "_nomreq"}, 32'(mem_req), 32'd0);
      if (k > 0 && k == delay && issue)
        check({tag, "_hold"}, mem_addr, maddr);
      mem_ack   = (k == delay);
      mem_rdata = (k == delay) ? rdata : 32'h0;
      if (rsp_valid)
        seen = k;
    end
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    check({tag, "_lat"}, 32'(seen), 32'(lat));
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    check({tag, "_rdy_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    req_dest   = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mreq", 32'(mem_req), 32'd0);
    check("rst_rspv", 32'(rsp_valid), 32'd0);
    check("rst_data", rsp_data, 32'd0);
    rst_n = 1'b1;

    access("sw", 1'b1, 3'b010, 32'h104,
           32'hDEADBEEF, 5'd7, 0, 32'h0, 1'b1,
           4'b1111, 32'hDEADBEEF, 1,
           32'h0, 5'd0, 1'b0);
    access("lb", 1'b0, 3'b000, 32'h103,
           32'h0, 5'd5, 0, 32'h80FFFF7F, 1'b1,
           4'b1000, 32'h0, 1,
           32'hFFFFFF80, 5'd5, 1'b0);
    access("lbu", 1'b0, 3'b100, 32'h103,
           32'h0, 5'd6, 0, 32'h80FFFF7F, 1'b1,
           4'b1000, 32'h0, 1,
           32'h00000080, 5'd6, 1'b0);
    access("lh", 1'b0, 3'b001, 32'h102,
           32'h0, 5'd9, 0, 32'h80011234, 1'b1,
           4'b1100, 32'h0, 1,
           32'hFFFF8001, 5'd9, 1'b0);
    access("sh", 1'b1, 3'b001, 32'h102,
           32'h1234ABCD, 5'd3, 0, 32'h0, 1'b1,
           4'b1100, 32'hABCDABCD, 1,
           32'h0, 5'd0, 1'b0);
    access("lhu", 1'b0, 3'b101, 32'h100,
           32'h0, 5'd10, 0, 32'h8001F234, 1'b1,
           4'b0011, 32'h0, 1,
           32'h0000F234, 5'd10, 1'b0);
    access("sb", 1'b1, 3'b000, 32'h101,
           32'h1234565A, 5'd4, 0, 32'h0, 1'b1,
           4'b0010, 32'h5A5A5A5A, 1,
           32'h0, 5'd0, 1'b0);
    access("lw_wait", 1'b0, 3'b010, 32'h200,
           32'h0, 5'd11, 3, 32'hCAFEF00D, 1'b1,
           4'b1111, 32'h0, 4,
           32'hCAFEF00D, 5'd11, 1'b0);
    access("lw_tmo", 1'b0, 3'b010, 32'h300,
           32'h0, 5'd12, -1, 32'h0, 1'b1,
           4'b1111, 32'h0, 16,
           32'h0, 5'd0, 1'b1);
    access("lw_edge", 1'b0, 3'b010, 32'h304,
           32'h0, 5'd13, 15, 32'h13579BDF, 1'b1,
           4'b1111, 32'h0, 16,
           32'h13579BDF, 5'd13, 1'b0);
    access("ill_011", 1'b0, 3'b011, 32'h10,
           32'h0, 5'd2, -1, 32'h0, 1'b0,
           4'b0000, 32'h0, 0,
           32'h0, 5'd0, 1'b1);
    access("ill_sbu", 1'b1, 3'b100, 32'h10,
           32'h55, 5'd2, -1, 32'h0, 1'b0,
           4'b0000, 32'h0, 0,
           32'h0, 5'd0, 1'b1);
`ifdef MISALIGN_TRAP_EN
    access("lw_mis", 1'b0, 3'b010, 32'h101,
           32'h0, 5'd14, -1, 32'h0, 1'b0,
           4'b0000, 32'h0, 0,
           32'h0, 5'd0, 1'b1);
`else
    access("lw_mis", 1'b0, 3'b010, 32'h101,
           32'h0, 5'd14, 0, 32'h11223344, 1'b1,
           4'b1111, 32'h0, 1,
           32'h11223344, 5'd14, 1'b0);
`endif

    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    check("idle_ack_rspv", 32'(rsp_valid), 32'd0);
    check("idle_ack_rdy", 32'(req_ready), 32'd1);
    mem_ack = 1'b0;

    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h400;
    req_dest   = 5'd15;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_pre", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_mreq", 32'(mem_req), 32'd0);
    check("rst_mid_maddr", mem_addr, 32'd0);
    check("rst_mid_rdy", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    mem_ack = 1'b0;
    check("rst_late_ack", 32'(rsp_valid), 32'd0);
    check("rst_late_rdy", 32'(req_ready), 32'd1);

    access("lw_after", 1'b0, 3'b010, 32'h408,
           32'h0, 5'd16, 1, 32'h76543210, 1'b1,
           4'b1111, 32'h0, 2,
           32'h76543210, 5'd16, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
